fp29i_to_fp16_out: RTL
======================

Name: fp29i_to_fp16_out

Overview:
Output stage of the FIR datapath. It takes the FP29i result produced by the FPALU at the end of the final normalize/accumulate cycle and converts it to IEEE FP16, using round-to-nearest-even, overflow saturation and flush-to-zero. It is a 3-stage pipeline and drives the FIR's dout/valid pins. Results are held between samples and carry per-result exception flags.

Parameters:
IN_EXP_BIAS, 63, bias of the 7-bit FP29i exponent
IN_FRAC_BITS, 20, binary-point position in the 22-bit FP29i mantissa (value = m/2^IN_FRAC_BITS)
OUT_SAT, 0, overflow result: 0 = ±Inf (0x7C00), 1 = ±max finite (0x7BFF)

Ports:
clk2  in  1  fast clock; all state on its posedge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  single-cycle strobe: in_fp29i holds a final result
in_fp29i  in  30  {s[29], e[28:22], m[21:0]}; m is unnormalized, no hidden bit
flush  in  1  synchronous pipeline kill
dout  out  16  FP16 result, held until the next result
valid  out  1  one-cycle pulse when dout updates
ovf  out  1  overflow flag for the current dout, held with dout
unf  out  1  underflow/flush-to-zero flag for the current dout, held with dout

Behaviour:
- Reset (async, rst_n=0): dout=0x0000, valid=0, ovf=0, unf=0; all stage-valid bits = 0. Reset may be asserted at any cycle; in-flight samples are discarded and no valid is produced for them.
- Fully pipelined: one sample per cycle is accepted, there is no backpressure, and latency is 3 cycles (in_valid at edge N gives valid=1 after edge N+3).
- S1 (capture): register s, e, m and count leading zeros lz of m (0..22, via sub-module). Compute E = e − IN_EXP_BIAS + 15 + 21 − IN_FRAC_BITS − lz as a signed 10-bit value (defaults: E = e − lz − 47). Set zero = (m==0).
- S2 (normalize/round): n = m << lz, so the leading one sits at n[21]. frac = n[20:11], guard = n[10], sticky = |n[9:0]. Round up if guard & (sticky | frac[0]). On a carry out of frac (0x3FF+1), frac=0 and E=E+1.
- S3 (pack/exceptions), in priority order:
  - zero: dout = {s,15'b0}, ovf=0, unf=0.
  - E ≥ 31 after rounding: ovf=1; dout = {s,0x7C00[14:0]} if OUT_SAT=0, else {s,0x7BFF[14:0]}.
  - E ≤ 0: unf=1, dout = {s,15'b0}. There are no subnormal outputs.
  - otherwise: dout = {s, E[4:0], frac}.
- dout, ovf and unf are loaded only when S3 is valid. valid = S3-valid registered, high for exactly one cycle per sample. Consecutive samples give consecutive valid pulses.
- flush=1: clears the S1/S2/S3 valid bits at that edge. dout and the flags keep their last value. If in_valid and flush are high in the same cycle, flush wins and the sample is dropped.
- An all-x sample with in_valid=0 never affects outputs, because data registers only propagate under the stage valid bit.

Decomposition:
- Shared package fir_fmt_pkg:
  - FP29i field widths and positions (S=29, E 28:22, M 21:0).
  - FP16 field widths, FP16_BIAS=15, FP16_INF=16'h7C00, FP16_MAXF=16'h7BFF.
  - Default IN_EXP_BIAS and IN_FRAC_BITS, shared with the FPALU wrapper.
- Sub-module fp_lzc22: combinational 22-bit leading-zero counter, output 5 bits (22 when the input is zero), instantiated in S1.

Test Plan:
- s=0, e=63, m=0x100000 (1.0) → dout=0x3C00, valid 3 cycles after in_valid, ovf=unf=0. With s=1 → dout=0xBC00. With m=0x200000 (2.0) → dout=0x4000.
- RNE ties and rounding carry:
  - m=0x100200 (tie, frac lsb 0) → 0x3C00.
  - m=0x100600 (tie, lsb 1) → 0x3C02.
  - m=0x100201 (above half) → 0x3C01.
  - m=0x1FFE00 (frac carry) → 0x4000.
- Exceptions:
  - e=127, m=0x100000 → 0x7C00 and ovf=1 (0x7BFF with OUT_SAT=1).
  - e=40, m=0x100000 → 0x0000 and unf=1.
  - m=0, s=1 → 0x8000 with no flags.
- Small mantissa: e=63, m=0x000001 (lz=21, E=−5) → 0x0000 with unf=1. e=90, m=0x000400 (lz=11, E=32) → overflow.
- Back-to-back inputs 1.0, 2.0, −1.0 on three consecutive cycles → three consecutive valid pulses with 0x3C00, 0x4000, 0xBC00. Between pulses, dout holds the last value.
- flush one cycle after in_valid → no valid pulse and dout unchanged. rst_n low mid-pipeline → outputs 0 immediately, and no valid after release.

Source files
------------

// File: rtl/fir_fmt_pkg.sv
// Shared number-format definitions for the FIR datapath.
//   - FP29i layout: {s[29], e[28:22], m[21:0]}, 7-bit biased exponent,
//     22-bit unnormalized mantissa with no hidden bit.
//   - FP16 (IEEE half) field widths and special encodings.
//   - Default FP29i exponent bias and binary-point position. These are
//     shared with the FPALU wrapper so both ends agree on the format.
package fir_fmt_pkg;

    // FP29i field positions
    localparam int FP29_W    = 30;
    localparam int FP29_S    = 29;
    localparam int FP29_E_HI = 28;
    localparam int FP29_E_LO = 22;
    localparam int FP29_E_W  = 7;
    localparam int FP29_M_HI = 21;
    localparam int FP29_M_W  = 22;

    // FP16 fields and special values
    localparam int FP16_W    = 16;
    localparam int FP16_E_W  = 5;
    localparam int FP16_F_W  = 10;
    localparam int FP16_BIAS = 15;
    localparam logic [15:0] FP16_INF  = 16'h7C00;
    localparam logic [15:0] FP16_MAXF = 16'h7BFF;

    // FP29i defaults (value = m / 2^IN_FRAC_BITS * 2^(e - IN_EXP_BIAS))
    localparam int DEF_IN_EXP_BIAS  = 63;
    localparam int DEF_IN_FRAC_BITS = 20;

endpackage

// File: rtl/fp_lzc22.sv
// Combinational leading-zero counter for a 22-bit mantissa.
// Ports:
//   m  : 22-bit input word
//   lz : number of leading zeros above the most significant one (0..21),
//        or 22 when m is zero
module fp_lzc22
    import fir_fmt_pkg::*;
(
    input  logic [FP29_M_W-1:0] m,
    output logic [4:0]          lz
);

    // Scan from LSB upward so the highest set bit wins.
    always_comb begin
        lz = 5'd22;
        for (int i = 0; i < FP29_M_W; i++) begin
            if (m[i]) begin
                lz = 5'(FP29_M_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp29i_to_fp16_out.sv
// FIR output stage: converts the final FP29i result from the FPALU into
// IEEE FP16 with round-to-nearest-even, overflow saturation (to Inf or to
// max finite, selected by OUT_SAT) and flush-to-zero for results too small
// for a normal FP16. Three-stage pipeline, one sample per cycle.
//
// Interface semantics: there is no ready/backpressure. in_valid is a
// one-cycle strobe qualifying in_fp29i; a sample strobed at edge N appears
// on dout with a one-cycle valid pulse after edge N+3. dout, ovf and unf
// hold their value until the next valid pulse. flush kills every sample in
// flight (including one strobed in the same cycle) without touching dout.
//
// Ports:
//   clk2     : clock, all state on posedge
//   rst_n    : asynchronous active-low reset
//   in_valid : input strobe
//   in_fp29i : {s, e[6:0], m[21:0]} FP29i value
//   flush    : synchronous pipeline kill
//   dout     : FP16 result (held)
//   valid    : one-cycle pulse when dout updates
//   ovf      : overflow flag for current dout (held)
//   unf      : underflow / flush-to-zero flag for current dout (held)
module fp29i_to_fp16_out
    import fir_fmt_pkg::*;
#(
    parameter int IN_EXP_BIAS  = DEF_IN_EXP_BIAS,
    parameter int IN_FRAC_BITS = DEF_IN_FRAC_BITS,
    parameter int OUT_SAT      = 0
) (
    input  logic              clk2,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [FP29_W-1:0] in_fp29i,
    input  logic              flush,
    output logic [FP16_W-1:0] dout,
    output logic              valid,
    output logic              ovf,
    output logic              unf
);

    // Exponent offset folding the input bias, FP16 bias and the shift that
    // places the leading one at mantissa bit 21 before the lz correction.
    localparam int EXP_OFF_I = FP16_BIAS + (FP29_M_W - 1) - IN_FRAC_BITS - IN_EXP_BIAS;
    localparam logic signed [9:0] EXP_OFF = EXP_OFF_I[9:0];
    localparam logic [14:0] OVF_MAG = (OUT_SAT != 0) ? FP16_MAXF[14:0] : FP16_INF[14:0];

    // ------------------------------------------------------------------
    // S1: capture fields, leading-zero count, unrounded exponent
    // ------------------------------------------------------------------
    logic                s_in;
    logic [FP29_E_W-1:0] e_in;
    logic [FP29_M_W-1:0] m_in;
    logic [4:0]          lz_in;
    logic signed [9:0]   exp_in;

    assign s_in = in_fp29i[FP29_S];
    assign e_in = in_fp29i[FP29_E_HI:FP29_E_LO];
    assign m_in = in_fp29i[FP29_M_HI:0];

    fp_lzc22 u_lzc (
        .m  (m_in),
        .lz (lz_in)
    );

    assign exp_in = $signed({3'b000, e_in}) - $signed({5'b00000, lz_in}) + EXP_OFF;

    logic                s1_v;
    logic                s1_s;
    logic signed [9:0]   s1_exp;
    logic [FP29_M_W-1:0] s1_m;
    logic [4:0]          s1_lz;
    logic                s1_zero;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_s    <= 1'b0;
            s1_exp  <= '0;
            s1_m    <= '0;
            s1_lz   <= '0;
            s1_zero <= 1'b0;
        end else begin
            s1_v <= in_valid & ~flush;
            if (in_valid) begin
                s1_s    <= s_in;
                s1_exp  <= exp_in;
                s1_m    <= m_in;
                s1_lz   <= lz_in;
                s1_zero <= (m_in == '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: normalize so the leading one sits at bit 21, then RNE round
    // ------------------------------------------------------------------
    logic [FP29_M_W-1:0] norm;
    logic [9:0]          frac_t;
    logic                guard;
    logic                sticky;
    logic                rnd_up;
    logic                carry;
    logic [9:0]          frac_r;
    logic signed [9:0]   exp_r;

    assign norm   = s1_m << s1_lz;
    assign frac_t = norm[20:11];
    assign guard  = norm[10];
    assign sticky = |norm[9:0];
    assign rnd_up = guard & (sticky | frac_t[0]);
    // A carry out of the fraction wraps it to zero and bumps the exponent.
    assign {carry, frac_r} = {1'b0, frac_t} + {10'b0, rnd_up};
    assign exp_r  = s1_exp + $signed({9'b0, carry});

    logic              s2_v;
    logic              s2_s;
    logic signed [9:0] s2_exp;
    logic [9:0]        s2_frac;
    logic              s2_zero;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            s2_s    <= 1'b0;
            s2_exp  <= '0;
            s2_frac <= '0;
            s2_zero <= 1'b0;
        end else begin
            s2_v <= s1_v & ~flush;
            if (s1_v) begin
                s2_s    <= s1_s;
                s2_exp  <= exp_r;
                s2_frac <= frac_r;
                s2_zero <= s1_zero;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: pack and classify (zero > overflow > underflow > normal)
    // ------------------------------------------------------------------
    logic [FP16_W-1:0] pk_dout;
    logic              pk_ovf;
    logic              pk_unf;

    always_comb begin
        pk_dout = {s2_s, 15'b0};
        pk_ovf  = 1'b0;
        pk_unf  = 1'b0;
        if (s2_zero) begin
            pk_dout = {s2_s, 15'b0};
        end else if (s2_exp >= 10'sd31) begin
            pk_ovf  = 1'b1;
            pk_dout = {s2_s, OVF_MAG};
        end else if (s2_exp <= 10'sd0) begin
            // No subnormal outputs: anything below the normal range flushes.
            pk_unf  = 1'b1;
            pk_dout = {s2_s, 15'b0};
        end else begin
            pk_dout = {s2_s, s2_exp[4:0], s2_frac};
        end
    end

    logic              s3_v;
    logic [FP16_W-1:0] s3_dout;
    logic              s3_ovf;
    logic              s3_unf;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            s3_v    <= 1'b0;
            s3_dout <= '0;
            s3_ovf  <= 1'b0;
            s3_unf  <= 1'b0;
        end else begin
            s3_v <= s2_v & ~flush;
            if (s2_v) begin
                s3_dout <= pk_dout;
                s3_ovf  <= pk_ovf;
                s3_unf  <= pk_unf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers: loaded only by a valid S3, held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            valid <= s3_v;
            if (s3_v) begin
                dout <= s3_dout;
                ovf  <= s3_ovf;
                unf  <= s3_unf;
            end
        end
    end

endmodule
